// File: rtl/fifo_wr_arb_pkg.sv
// Shared types and defaults for the FIFO write-port arbiter.
// Holds the FSM state enum, parameter defaults and the index-wrap helper.
package fifo_wr_arb_pkg;

  typedef enum logic {
    ARB   = 1'b0,
    BURST = 1'b1
  } state_e;

  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_MAX_BURST  = 4;

  function automatic int unsigned wrap_inc(
    input int unsigned i,
    input int unsigned n
  );
    return (i + 1 >= n) ? 0 : i + 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin pick: first set req at index >= ptr, with wrap.
// Ports: req, ptr in; grant (one-hot), idx, valid out.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          valid
);

  always_comb begin
    int j;
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!valid && req[j]) begin
        valid    = 1'b1;
        grant[j] = 1'b1;
        idx      = IW'(j);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers.
// Ports: clk, rst, req, lock, wdata, fifo_full in; ack, fifo_w_en,
// fifo_data_in, owner, busy out. FIFO_WR_ARB_STATS_EN adds stat_cnt,
// stall_cnt.
module fifo_wr_arbiter
  import fifo_wr_arb_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MAX_BURST  = DEF_MAX_BURST,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            lock,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] wdata,
  output logic [NUM_REQ-1:0]            ack,
  input  logic                          fifo_full,
  output logic                          fifo_w_en,
  output logic [DATA_WIDTH-1:0]         fifo_data_in,
  output logic [$clog2(NUM_REQ)-1:0]    owner,
  output logic                          busy
`ifdef FIFO_WR_ARB_STATS_EN
  ,
  output logic [NUM_REQ*CNT_WIDTH-1:0]  stat_cnt,
  output logic [CNT_WIDTH-1:0]          stall_cnt
`endif
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] MAXB = CW'(MAX_BURST);
  localparam int DW = DATA_WIDTH;

  state_e          state, state_n;
  logic [IW-1:0]   rr_ptr, rr_n;
  logic [IW-1:0]   owner_n;
  logic [CW-1:0]   burst_cnt, cnt_n, cnt_inc;

  logic [NUM_REQ-1:0] pick_grant;
  logic [IW-1:0]      pick_idx;
  logic               pick_valid;

  rr_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_pick (
    .req   (req),
    .ptr   (rr_ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  assign cnt_inc = burst_cnt + 1'b1;
  assign busy    = (state == BURST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ARB;
      rr_ptr    <= '0;
      owner     <= '0;
      burst_cnt <= '0;
    end else begin
      state     <= state_n;
      rr_ptr    <= rr_n;
      owner     <= owner_n;
      burst_cnt <= cnt_n;
    end
  end

  // A full FIFO freezes everything, including a pending burst exit.
  always_comb begin
    ack          = '0;
    fifo_w_en    = 1'b0;
    fifo_data_in = '0;
    state_n      = state;
    rr_n         = rr_ptr;
    owner_n      = owner;
    cnt_n        = burst_cnt;
    if (!rst && !fifo_full) begin
      unique case (state)
        ARB: begin
          if (pick_valid) begin
            ack          = pick_grant;
            fifo_w_en    = 1'b1;
            fifo_data_in = wdata[int'(pick_idx)*DW +: DW];
            rr_n         = IW'(wrap_inc(int'(pick_idx), NUM_REQ));
            owner_n      = pick_idx;
            if (lock[pick_idx] && MAX_BURST > 1) begin
              state_n = BURST;
              cnt_n   = CW'(1);
            end
          end
        end
        BURST: begin
          if (req[owner]) begin
            ack[owner]   = 1'b1;
            fifo_w_en    = 1'b1;
            fifo_data_in = wdata[int'(owner)*DW +: DW];
            cnt_n        = cnt_inc;
          end
          if (!req[owner] || !lock[owner] || cnt_inc == MAXB) begin
            state_n = ARB;
            cnt_n   = '0;
          end
        end
        default: state_n = ARB;
      endcase
    end
  end

`ifdef FIFO_WR_ARB_STATS_EN
  logic stall_ev;

  assign stall_ev = fifo_full &&
                    ((state == ARB) ? |req : req[owner]);

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (ack[i] && stat_cnt[i*CNT_WIDTH +: CNT_WIDTH] != '1)
          stat_cnt[i*CNT_WIDTH +: CNT_WIDTH] <=
            stat_cnt[i*CNT_WIDTH +: CNT_WIDTH] + 1'b1;
      end
      if (stall_ev && stall_cnt != '1)
        stall_cnt <= stall_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed self-checking bench for fifo_wr_arbiter.
// Stats checks compile in only with FIFO_WR_ARB_STATS_EN.
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req;
  logic [N-1:0]  lock;
  logic [N*DW-1:0] wdata;
  logic [N-1:0]  ack;
  logic          fifo_full;
  logic          fifo_w_en;
  logic [DW-1:0] fifo_data_in;
  logic [1:0]    owner;
  logic          busy;
`ifdef FIFO_WR_ARB_STATS_EN
  logic [N*CW-1:0] stat_cnt;
  logic [CW-1:0]   stall_cnt;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(
    .NUM_REQ    (N),
    .DATA_WIDTH (DW),
    .MAX_BURST  (4),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .lock         (lock),
    .wdata        (wdata),
    .ack          (ack),
    .fifo_full    (fifo_full),
    .fifo_w_en    (fifo_w_en),
    .fifo_data_in (fifo_data_in),
    .owner        (owner),
    .busy         (busy)
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    .stat_cnt     (stat_cnt),
    .stall_cnt    (stall_cnt)
`endif
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check one cycle's combinational outputs, then advance a cycle.
  task automatic cyc(input string tag,
                     input logic [N-1:0] e_ack,
                     input logic e_busy);
    logic [DW-1:0] e_data;
    e_data = '0;
    for (int i = 0; i < N; i++)
      if (e_ack[i]) e_data = wdata[i*DW +: DW];
    #1;
    chk({tag, "_ack"}, 32'(ack), 32'(e_ack));
    chk({tag, "_wen"}, 32'(fifo_w_en), 32'(|e_ack));
    chk({tag, "_data"}, 32'(fifo_data_in), 32'(e_data));
    chk({tag, "_busy"}, 32'(busy), 32'(e_busy));
    tick();
  endtask

  initial begin
    rst       = 1'b1;
    req       = 4'b1111;
    lock      = 4'b0000;
    fifo_full = 1'b0;
    wdata     = {8'hA3, 8'hA2, 8'hA1, 8'hA0};

    for (int k = 0; k < 5; k++) cyc("rst", 4'b0000, 1'b0);
    rst = 1'b0;
    #1;
    chk("rst_owner", 32'(owner), 32'd0);

    for (int k = 0; k < 8; k++)
      cyc("fair", 4'(1 << (k % 4)), 1'b0);

    req = 4'b0000;
    cyc("idle", 4'b0000, 1'b0);

    // Steer rr_ptr to 2, then burst limit.
    req = 4'b0010;
    cyc("pre_b", 4'b0010, 1'b0);
    req  = 4'b1111;
    lock = 4'b0100;
    cyc("burst1", 4'b0100, 1'b0);
    #1;
    chk("burst_owner", 32'(owner), 32'd2);
    cyc("burst2", 4'b0100, 1'b1);
    cyc("burst3", 4'b0100, 1'b1);
    cyc("burst4", 4'b0100, 1'b1);
    cyc("burst_nx", 4'b1000, 1'b0);

    // Full mid-burst.
    req = 4'b0010;
    cyc("pre_f", 4'b0010, 1'b0);
    req = 4'b1111;
    cyc("fb1", 4'b0100, 1'b0);
    cyc("fb2", 4'b0100, 1'b1);
    fifo_full = 1'b1;
    for (int k = 0; k < 3; k++) cyc("fb_full", 4'b0000, 1'b1);
    fifo_full = 1'b0;
    cyc("fb3", 4'b0100, 1'b1);
    cyc("fb4", 4'b0100, 1'b1);
    cyc("fb_nx", 4'b1000, 1'b0);
    lock = 4'b0000;

    // Sparse wrap from rr_ptr=3.
    req = 4'b0100;
    cyc("pre_s", 4'b0100, 1'b0);
    req = 4'b1001;
    cyc("sp1", 4'b1000, 1'b0);
    cyc("sp2", 4'b0001, 1'b0);

    // Reset mid-burst drops the burst without writing.
    req  = 4'b0010;
    lock = 4'b0010;
    cyc("rb1", 4'b0010, 1'b0);
    rst = 1'b1;
    cyc("rb_rst", 4'b0000, 1'b1);
    rst  = 1'b0;
    req  = 4'b1111;
    lock = 4'b0000;
    cyc("rb_after", 4'b0001, 1'b0);

`ifdef FIFO_WR_ARB_STATS_EN
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = 4'b0010;
    for (int k = 0; k < 10; k++) tick();
    fifo_full = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    fifo_full = 1'b0;
    req = 4'b0000;
    #1;
    chk("stat1", 32'(stat_cnt[1*CW +: CW]), 32'd10);
    chk("stall", 32'(stall_cnt), 32'd3);
    chk("stat0", 32'(stat_cnt[0 +: CW]), 32'd0);
    req = 4'b0010;
    for (int k = 0; k < 20; k++) tick();
    req = 4'b0000;
    #1;
    chk("stat1_sat", 32'(stat_cnt[1*CW +: CW]), 32'd15);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write arbiter that shares the write port of one synchronous FIFO (w_en/data_in/full interface) between NUM_REQ producers.
- Each producer holds a level request plus data. The arbiter grants one producer per cycle and drives the FIFO write strobe and data.
- A producer may lock the port for a bounded burst of up to MAX_BURST consecutive words.
- Sits directly in front of the FIFO write side; the read side is untouched.

Parameters:
- NUM_REQ, 4, number of producers (2..16).
- DATA_WIDTH, 8, FIFO word width.
- MAX_BURST, 4, maximum consecutive words per locked grant (1 disables bursting).
- CNT_WIDTH, 16, width of statistics counters (optional feature only).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-producer write request (level).
- lock  in  NUM_REQ  per-producer burst request, valid while req is set.
- wdata  in  NUM_REQ*DATA_WIDTH  packed producer data; slice i belongs to producer i.
- ack  out  NUM_REQ  one-hot; word from producer i written this cycle.
- fifo_full  in  1  FIFO full flag.
- fifo_w_en  out  1  FIFO write enable.
- fifo_data_in  out  DATA_WIDTH  FIFO write data.
- owner  out  clog2(NUM_REQ)  index of current/last granted producer.
- busy  out  1  high while in BURST state.

Behaviour:
- Handshake:
  - Producer raises req[i] and holds req[i] and wdata slice i stable until it sees ack[i].
  - Each ack[i] cycle is one word written.
  - Producer may change data or drop req after ack.
- Zero latency:
  - fifo_w_en, fifo_data_in and ack are combinational from the state registers, req, lock and fifo_full.
  - fifo_w_en is high exactly when one ack bit is high.
  - fifo_data_in equals wdata[owner-of-ack]; when no ack, fifo_data_in is 0.
- FSM has two states: ARB and BURST.
- ARB state:
  - If any req and !fifo_full: the winner is the first set req at index ≥ rr_ptr, searching with wrap NUM_REQ-1→0.
  - On a win: ack[winner]=1, fifo_w_en=1; next cycle rr_ptr=winner+1 (mod NUM_REQ), owner=winner.
  - If lock[winner] && MAX_BURST>1: next state is BURST with burst_cnt=1.
- BURST state:
  - Only owner is served; all other requests wait.
  - If req[owner] && !fifo_full: write, burst_cnt+1.
  - Return to ARB after the cycle in which any of these holds: lock[owner]=0, req[owner]=0, or burst_cnt reaches MAX_BURST with this write.
  - When leaving because req or lock dropped, no write occurs that cycle unless req[owner] is still high.
- fifo_full=1: no ack, no fifo_w_en. rr_ptr, burst_cnt and state are held. fifo_full is never overridden.
- No requests: outputs idle, state held.
- Reset:
  - While rst=1: ack=0, fifo_w_en=0, fifo_data_in=0.
  - Next state after reset: ARB, rr_ptr=0, owner=0, burst_cnt=0, busy=0.
  - Reset mid-burst abandons the burst with no partial write.
- req bits are ignored during reset.

Optional Feature:
- Macro FIFO_WR_ARB_STATS_EN.
- Defined:
  - Adds output stat_cnt (NUM_REQ*CNT_WIDTH): per-producer count of accepted words.
  - Adds output stall_cnt (CNT_WIDTH): cycles in which a serviceable request was blocked by fifo_full. In ARB that means any req; in BURST it means req[owner].
  - All counters saturate at all-ones, reset to 0, and increment on the same edge the event is seen.
- Undefined: the ports and counters are absent; the rest of the behaviour is identical.

Decomposition:
- Package fifo_wr_arb_pkg holds:
  - state enum (ARB, BURST);
  - default NUM_REQ, DATA_WIDTH, MAX_BURST;
  - a helper function for next-index wrap.
- One sub-module, rr_pick: combinational round-robin pick.
  - Inputs: req vector and rr_ptr.
  - Outputs: one-hot grant, index, and a valid bit.
  - Instantiated once.

Test Plan:
- Reset: req=1111 held through 5 reset cycles → ack=0 and fifo_w_en=0 throughout; on the first cycle after rst falls, ack=0001 and fifo_data_in=wdata[0].
- Fairness: req=1111, lock=0, fifo_full=0 for 8 cycles → ack sequence 0001,0010,0100,1000,0001,0010,0100,1000; fifo_w_en=1 every cycle.
- Burst limit: rr_ptr=2, req=1111, lock=0100, MAX_BURST=4 → ack=0100 for 4 consecutive cycles with busy=1 on cycles 2–4, then ack=1000.
- Full mid-burst: same setup, fifo_full=1 for 3 cycles after the 2nd burst word → ack=0 and fifo_w_en=0 for those 3 cycles, then 2 more ack=0100 words (total 4), then ack=1000.
- Sparse wrap: rr_ptr=3, req=1001 → ack=1000, then ack=0001.
- Stats (macro on, CNT_WIDTH=4):
  - 10 accepts from producer 1 plus 3 full-stall cycles → stat_cnt[1]=10, stall_cnt=3.
  - 20 further accepts → stat_cnt[1]=15 (saturated).
